frame_downloader: RTL and testbench

FRAME_DOWNLOADER -- requirements
Module: frame_downloader

---
 rtl/frame_downloader.sv | 184 ++++++++++++++++++
 tb/tb_frame_downloader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_downloader.sv
// frame_downloader: reads a frame from PSRAM one 16-pixel burst at a time and
// streams the pixels, tagged with a start-of-frame bit, into a pixel FIFO.
module frame_downloader #(
  parameter int MEMORY_BURST = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [20:0] base_addr,
  input  logic        read_ack,
  input  logic        read_data_valid,
  input  logic [31:0] read_data,
  input  logic        queue_full,
  output logic        read_rq,
  output logic        mem_rd_en,
  output logic [20:0] read_addr,
  output logic        queue_wr_en,
  output logic [16:0] queue_data,
  output logic        download_done
);

  // One burst holds MEMORY_BURST bytes = MEMORY_BURST/2 pixels (16-bit units).
  localparam int          PIX_PER_BURST = MEMORY_BURST / 2;
  localparam logic [20:0] ADDR_STEP     = 21'(PIX_PER_BURST);
  localparam logic [14:0] TOTAL_BURSTS  = 15'(FRAME_WIDTH * FRAME_HEIGHT / PIX_PER_BURST);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ_WAIT = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_RECEIVE  = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_RELEASE  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [20:0] r_frame_addr;
  logic [14:0] r_burst_cnt;
  logic [2:0]  r_word_cnt;
  logic [3:0]  r_pix_idx;
  logic        r_sof_pending;
  logic        r_primed;
  logic [31:0] r_buf [8];

  logic        r_read_rq;
  logic        r_mem_rd_en;
  logic [20:0] r_read_addr;
  logic        r_download_done;

  logic        w_drain_wr;
  logic        w_last_pix;
  logic [14:0] w_burst_next;
  logic [31:0] w_word;
  logic [15:0] w_pix;
  logic        w_sof;

  // The first DRAIN cycle is a settle cycle (r_primed=0), so pixel 0 never
  // appears earlier than two cycles after the final burst word.
  assign w_drain_wr   = (r_state == S_DRAIN) && r_primed && !queue_full;
  assign w_last_pix   = w_drain_wr && (r_pix_idx == 4'd15);
  assign w_burst_next = r_burst_cnt + 15'd1;
  assign w_word       = r_buf[r_pix_idx[3:1]];
  assign w_pix        = r_pix_idx[0] ? w_word[31:16] : w_word[15:0];
  assign w_sof        = r_sof_pending && (r_pix_idx == 4'd0);

  // The write strobe must follow queue_full in the same cycle, so it is
  // gated combinationally from registered state; data is zero when idle.
  assign queue_wr_en   = w_drain_wr;
  assign queue_data    = w_drain_wr ? {w_sof, w_pix} : 17'd0;
  assign read_rq       = r_read_rq;
  assign mem_rd_en     = r_mem_rd_en;
  assign read_addr     = r_read_addr;
  assign download_done = r_download_done;

  // Next-state decision for the burst sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_REQ_WAIT;
        else       w_next = S_IDLE;
      end
      S_REQ_WAIT: begin
        if (read_ack) w_next = S_ISSUE;
        else          w_next = S_REQ_WAIT;
      end
      S_ISSUE: begin
        w_next = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (read_data_valid && (r_word_cnt == 3'd7)) w_next = S_DRAIN;
        else                                         w_next = S_RECEIVE;
      end
      S_DRAIN: begin
        if (w_last_pix) begin
          if (w_burst_next == TOTAL_BURSTS) w_next = S_DONE;
          else                              w_next = S_RELEASE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_RELEASE: begin
        // Wait for the previous grant to disappear before asking again.
        if (!read_ack) w_next = S_REQ_WAIT;
        else           w_next = S_RELEASE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, address, counters and start-of-frame tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_frame_addr  <= 21'd0;
      r_burst_cnt   <= 15'd0;
      r_word_cnt    <= 3'd0;
      r_pix_idx     <= 4'd0;
      r_sof_pending <= 1'b0;
      r_primed      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_frame_addr  <= base_addr;
            r_burst_cnt   <= 15'd0;
            r_sof_pending <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_word_cnt <= 3'd0;
        end
        S_RECEIVE: begin
          r_pix_idx <= 4'd0;
          r_primed  <= 1'b0;
          if (read_data_valid) r_word_cnt <= r_word_cnt + 3'd1;
        end
        S_DRAIN: begin
          r_primed <= 1'b1;
          if (w_drain_wr) begin
            r_pix_idx <= r_pix_idx + 4'd1;
            if (r_pix_idx == 4'd0) r_sof_pending <= 1'b0;
          end
          if (w_last_pix) begin
            r_burst_cnt <= w_burst_next;
            // 21-bit wrap-around is intended; the carry is simply dropped.
            if (w_burst_next != TOTAL_BURSTS) r_frame_addr <= r_frame_addr + ADDR_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Burst word capture; only words arriving while receiving are kept.
  always_ff @(posedge clk) begin
    if ((r_state == S_RECEIVE) && read_data_valid) r_buf[r_word_cnt] <= read_data;
  end

  // Registered memory-side outputs, decoded from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_rq       <= 1'b0;
      r_mem_rd_en     <= 1'b0;
      r_read_addr     <= 21'd0;
      r_download_done <= 1'b0;
    end else begin
      r_read_rq       <= (w_next == S_REQ_WAIT) || (w_next == S_ISSUE) || (w_next == S_RECEIVE);
      r_mem_rd_en     <= (w_next == S_ISSUE);
      if (w_next == S_ISSUE) r_read_addr <= r_frame_addr;
      r_download_done <= (w_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_frame_downloader.sv
// Bench for frame_downloader: bench-side arbiter, PSRAM and FIFO models with
// a pixel/address scoreboard derived from the words the memory model sends.
module tb_frame_downloader;
  localparam int FW   = 32;
  localparam int FH   = 2;
  localparam int NB   = FW * FH / 16;
  localparam int NPIX = FW * FH;

  logic        clk, reset, start;
  logic [20:0] base_addr;
  logic        read_ack, read_data_valid, queue_full;
  logic [31:0] read_data;
  logic        read_rq, mem_rd_en, queue_wr_en, download_done;
  logic [20:0] read_addr;
  logic [16:0] queue_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int ack_dly_max = 0;
  int ack_hold = 0;
  int gap_max = 0;
  int qmode = 0;
  bit pattern_mode = 0;
  bit spur_en = 0;

  logic [16:0] exp_pix[$];
  logic [20:0] exp_addr[$];
  logic [16:0] got_pix[$];
  logic [20:0] got_addr[$];
  bit frame_first = 0;
  int word_idx = 0;
  int last_word_cyc = 0;
  int done_cnt = 0;
  int mem_pending = 0;

  frame_downloader #(.MEMORY_BURST(32), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .read_ack(read_ack), .read_data_valid(read_data_valid), .read_data(read_data),
    .queue_full(queue_full), .read_rq(read_rq), .mem_rd_en(mem_rd_en),
    .read_addr(read_addr), .queue_wr_en(queue_wr_en), .queue_data(queue_data),
    .download_done(download_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Arbiter: grants after a random delay, holds the grant for ack_hold cycles after read_rq drops.
  initial begin
    int dly;
    int hold;
    dly = 0;
    hold = 0;
    read_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        read_ack = 1'b0;
        dly = $urandom_range(ack_dly_max, 0);
      end else if (read_rq) begin
        hold = ack_hold;
        if (!read_ack) begin
          if (dly == 0) read_ack = 1'b1;
          else dly--;
        end
      end else begin
        dly = $urandom_range(ack_dly_max, 0);
        if (read_ack) begin
          if (hold == 0) read_ack = 1'b0;
          else hold--;
        end
      end
    end
  end

  // PSRAM: 8 words per command with random gaps; each word feeds the expected pixel stream.
  initial begin
    int gap;
    logic [31:0] w;
    gap = 0;
    read_data_valid = 1'b0;
    read_data = 32'd0;
    forever begin
      @(negedge clk);
      read_data_valid = 1'b0;
      if (reset) begin
        mem_pending = 0;
      end else if (mem_rd_en) begin
        mem_pending = 8;
        gap = $urandom_range(gap_max, 0);
      end else if (mem_pending > 0) begin
        if (gap > 0) begin
          gap--;
        end else begin
          if (pattern_mode) w = {16'(2 * word_idx + 2), 16'(2 * word_idx + 1)};
          else w = $urandom;
          word_idx++;
          read_data_valid = 1'b1;
          read_data = w;
          exp_pix.push_back({frame_first, w[15:0]});
          frame_first = 1'b0;
          exp_pix.push_back({1'b0, w[31:16]});
          mem_pending--;
          if (mem_pending == 0) last_word_cyc = cyc;
          gap = $urandom_range(gap_max, 0);
        end
      end else if (spur_en && ($urandom_range(3, 0) == 0)) begin
        read_data_valid = 1'b1;
        read_data = $urandom;
      end
    end
  end

  // FIFO fullness: never, random, or alternating every cycle.
  initial begin
    queue_full = 1'b0;
    forever begin
      @(negedge clk);
      case (qmode)
        0: queue_full = 1'b0;
        1: queue_full = ($urandom_range(2, 0) == 0);
        2: queue_full = ~queue_full;
        default: queue_full = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the scoreboard, sampled just before the rising edge.
  initial begin
    logic prev_rq, prev_ack, prev_done;
    logic [16:0] e;
    logic [20:0] ea;
    int pib, first_cyc;
    prev_rq = 1'b0; prev_ack = 1'b0; prev_done = 1'b0;
    pib = 0; first_cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check(!read_rq && !mem_rd_en && !queue_wr_en && !download_done && read_addr == 21'd0 && queue_data == 17'd0,
              "reset_outputs", {read_rq, mem_rd_en, queue_wr_en, download_done, read_addr, queue_data}, 0);
        pib = 0;
      end else begin
        if (mem_rd_en) begin
          got_addr.push_back(read_addr);
          if (exp_addr.size() == 0) check(1'b0, "unexpected_burst", read_addr, 0);
          else begin
            ea = exp_addr.pop_front();
            check(read_addr == ea, "read_addr", read_addr, ea);
          end
        end
        if (queue_wr_en) begin
          check(!queue_full, "write_while_full", queue_full, 0);
          got_pix.push_back(queue_data);
          if (exp_pix.size() == 0) check(1'b0, "extra_pixel", queue_data, 0);
          else begin
            e = exp_pix.pop_front();
            check(queue_data == e, "pixel", queue_data, e);
          end
          if (pib == 0) begin
            first_cyc = cyc;
            check(cyc - last_word_cyc >= 2, "first_pixel_latency", cyc - last_word_cyc, 2);
          end
          if (pib == 15) begin
            if (qmode == 0) check(cyc - first_cyc == 15, "drain_span_full_rate", cyc - first_cyc, 15);
            else if (qmode == 2) check(cyc - first_cyc == 30, "drain_span_toggle", cyc - first_cyc, 30);
          end
          pib = (pib + 1) % 16;
        end
        if (read_rq && !prev_rq) check(!prev_ack, "rq_after_ack_low", prev_ack, 0);
        if (download_done) begin
          done_cnt++;
          check(!prev_done, "done_single_cycle", prev_done, 0);
          check(exp_pix.size() == 0, "done_pixels_pending", exp_pix.size(), 0);
          check(exp_addr.size() == 0, "done_bursts_pending", exp_addr.size(), 0);
        end
      end
      prev_rq = read_rq;
      prev_ack = read_ack;
      prev_done = download_done;
    end
  end

  task automatic start_frame(input logic [20:0] base);
    exp_addr.delete(); got_addr.delete(); got_pix.delete(); exp_pix.delete();
    for (int k = 0; k < NB; k++) exp_addr.push_back(base + 21'(16 * k));
    frame_first = 1'b1;
    word_idx = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    base_addr = 21'($urandom);
  endtask

  task automatic wait_done(input bit inject_start);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
      if (inject_start && n == 20) begin
        start = 1'b1;
        base_addr = 21'h0ABCDE;
      end else begin
        start = 1'b0;
      end
    end
    check(done_cnt > 0, "frame_timeout", n, 0);
    repeat (30) @(negedge clk);
    check(done_cnt == 1, "done_pulse_count", done_cnt, 1);
    check(got_pix.size() == NPIX, "pixel_count", got_pix.size(), NPIX);
    check(got_addr.size() == NB, "burst_count", got_addr.size(), NB);
  endtask

  initial begin
    logic [20:0] lit_addr [4];
    int sofs, n;
    lit_addr = '{21'h000100, 21'h000110, 21'h000120, 21'h000130};
    reset = 1'b1; start = 1'b0; base_addr = 21'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frame A: base 0x100, immediate ack, FIFO never full, counting pattern.
    pattern_mode = 1; qmode = 0; ack_dly_max = 0; ack_hold = 0; gap_max = 0; spur_en = 0;
    start_frame(21'h000100);
    wait_done(1'b0);
    for (int i = 0; i < 4; i++)
      if (i < got_addr.size()) check(got_addr[i] == lit_addr[i], "frameA_addr", got_addr[i], lit_addr[i]);
    for (int i = 0; i < 16; i++)
      if (i < got_pix.size()) check(got_pix[i][15:0] == 16'(i + 1), "frameA_pixel_order", got_pix[i][15:0], i + 1);
    sofs = 0;
    foreach (got_pix[i]) if (got_pix[i][16]) sofs++;
    check(sofs == 1, "frameA_sof_count", sofs, 1);
    if (got_pix.size() > 0) check(got_pix[0][16] == 1'b1, "frameA_sof_first", got_pix[0][16], 1);

    // Frame B: FIFO full on alternate cycles, grant held 3 cycles after release.
    pattern_mode = 0; qmode = 2; ack_hold = 3; spur_en = 1;
    start_frame(21'($urandom));
    wait_done(1'b1);

    // Frame C: address wrap near the top of the 21-bit space, long grant hold.
    qmode = 1; ack_dly_max = 3; ack_hold = 20; gap_max = 2;
    start_frame(21'h1FFFF8);
    wait_done(1'b1);
    if (got_addr.size() > 1) check(got_addr[1] == 21'h000008, "frameC_addr_wrap", got_addr[1], 21'h000008);

    // Randomised frames.
    for (int f = 0; f < 4; f++) begin
      qmode = $urandom_range(2, 0);
      ack_dly_max = $urandom_range(3, 0);
      ack_hold = $urandom_range(24, 0);
      gap_max = $urandom_range(2, 0);
      start_frame(21'($urandom));
      wait_done(1'b1);
    end

    // Reset in the middle of a burst, then a fresh frame.
    qmode = 0; ack_dly_max = 1; ack_hold = 2; gap_max = 1;
    start_frame(21'h0A0000);
    n = 0;
    while (word_idx < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(word_idx >= 4, "midburst_timeout", word_idx, 4);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_pix.delete(); exp_addr.delete();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check(!read_rq && !mem_rd_en && !queue_wr_en && !download_done, "post_reset_quiet",
            {read_rq, mem_rd_en, queue_wr_en, download_done}, 0);
    end
    start_frame(21'h054320);
    wait_done(1'b0);
    if (got_addr.size() > 0) check(got_addr[0] == 21'h054320, "after_reset_base", got_addr[0], 21'h054320);
    if (got_pix.size() > 0) check(got_pix[0][16] == 1'b1, "after_reset_sof", got_pix[0][16], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
